// File: rtl/seq_divider_restoring.sv
// Sequential unsigned restoring divider: one shift plus trial subtract per RUN cycle.
// A zero divisor completes right away with an all-ones quotient and the dividend as remainder.
module seq_divider_restoring #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    p_q, p_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [W-1:0]    p_shift;
  logic [W:0]      trial;
  logic            qbit;
  logic [W-1:0]    p_next;
  logic [W-1:0]    a_next;

  // One restoring step: the carry out of P' + ~B + 1 means P' >= B, so the subtract is kept.
  always_comb begin
    p_shift = {p_q[W-2:0], a_q[W-1]};
    trial   = {1'b0, p_shift} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};
    qbit    = trial[W];
    p_next  = qbit ? trial[W-1:0] : p_shift;
    a_next  = {a_q[W-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = StDone;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
            a_d     = dividend;
            b_d     = divisor;
            p_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      StRun: begin
        a_d   = a_next;
        p_d   = p_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StDone;
          quo_d   = a_next;
          rem_d   = p_next;
          dbz_d   = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_restoring.sv
// Bench for seq_divider_restoring: vector table, hand sequences and exhaustive sweep,
// with expected results queued at start and compared when done pulses.
module tb_seq_divider_restoring;

  localparam int unsigned W = 4;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  seq_divider_restoring #(.W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Result monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz || cyc != e.cyc
            || busy !== 1'b1) begin
          errors++;
          $display("FAIL result: got q=%0d r=%0d dbz=%0b cyc=%0d busy=%0b, required q=%0d r=%0d dbz=%0b cyc=%0d busy=1",
                   quotient, remainder, div_by_zero, cyc, busy, e.q, e.r, e.dbz, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%0b after 100 cycles, required 0", busy);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results pending after 100 cycles, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Launch one operation; latency is 0 for a zero divisor, else W edges after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic edbz);
    exp_t e;
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.cyc = edbz ? cyc : cyc + W;
    sb.push_back(e);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: a=%0d b=%0d got busy=%0b, required 1", a, b, busy);
    end
    drain();
  endtask

  initial begin
    exp_t e;
    int   ks;
    tbl[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1,  dbz: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  dbz: 1'b0};
    tbl[2] = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3,  dbz: 1'b0};
    tbl[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0,  dbz: 1'b0};
    tbl[4] = '{a: 4'd7,  b: 4'd0,  q: 4'hF,  r: 4'd7,  dbz: 1'b1};
    tbl[5] = '{a: 4'd6,  b: 4'd3,  q: 4'd2,  r: 4'd0,  dbz: 1'b0};
    tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0,  dbz: 1'b0};
    tbl[7] = '{a: 4'd1,  b: 4'd0,  q: 4'hF,  r: 4'd1,  dbz: 1'b1};

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    reset = 1'b1;

    for (int i = 0; i < 8; i++) do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz);

    // Operands and start toggled while running must not disturb the result.
    wait_idle();
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    e     = '{q: 4'd3, r: 4'd1, dbz: 1'b0, cyc: cyc + W};
    sb.push_back(e);
    @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = 4'd2;
    divisor  = 4'd1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    start = 1'b0;
    drain();
    repeat (6) @(negedge clock);

    // Start held high re-triggers on the first idle cycle after DONE.
    wait_idle();
    start    = 1'b1;
    dividend = 4'd10;
    divisor  = 4'd3;
    @(posedge clock);
    #1;
    ks = cyc;
    e  = '{q: 4'd3, r: 4'd1, dbz: 1'b0, cyc: ks + W};
    sb.push_back(e);
    e  = '{q: 4'd3, r: 4'd1, dbz: 1'b0, cyc: ks + 2 * W + 2};
    sb.push_back(e);
    repeat (W + 2) @(posedge clock);
    #1;
    start = 1'b0;
    drain();

    // Reset during RUN at count=2 aborts with no done.
    wait_idle();
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd2;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    do_op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(W'(a), W'(b), W'(a / b), W'(a % b), 1'b0);
      end
    end

    repeat (4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
